// File: rtl/move_seq_pkg.sv
// Shared types and constants for the move sequencer.
// Define MOVE_SEQ_FAST_SIM_EN to use coarse ramp steps for short simulations.
package move_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        RAMP_UP,
        CRUISE,
        RAMP_DN,
        DONE
    } state_t;

    localparam logic [9:0]  FRWRD_MAX    = 10'h120;
    localparam logic [9:0]  FRWRD_INC    = 10'h008;
    localparam logic [11:0] HDG_TOL      = 12'h02C;
    localparam logic [5:0]  LINES_PER_SQ = 6'd2;

`ifdef MOVE_SEQ_FAST_SIM_EN
    localparam logic [9:0] RAMP_UP_STEP = 10'(4 * FRWRD_INC);
    localparam logic [9:0] RAMP_DN_STEP = 10'(8 * FRWRD_INC);
`else
    localparam logic [9:0] RAMP_UP_STEP = FRWRD_INC;
    localparam logic [9:0] RAMP_DN_STEP = 10'(2 * FRWRD_INC);
`endif

endpackage

// File: rtl/move_seq_if.sv
// Command, sensor and PID-facing signals of the move sequencer.
interface move_seq_if;
    logic        cmd_vld;
    logic [11:0] cmd_hdg;
    logic [3:0]  cmd_sqrs;
    logic [11:0] heading;
    logic        heading_rdy;
    logic        cntrIR;
    logic        cmd_rdy;
    logic        moving;
    logic        err_vld;
    logic [11:0] error;
    logic [9:0]  frwrd;
    logic        mv_done;

    modport master (
        output cmd_vld, cmd_hdg, cmd_sqrs, heading, heading_rdy, cntrIR,
        input  cmd_rdy, moving, err_vld, error, frwrd, mv_done
    );

    modport slave (
        input  cmd_vld, cmd_hdg, cmd_sqrs, heading, heading_rdy, cntrIR,
        output cmd_rdy, moving, err_vld, error, frwrd, mv_done
    );
endinterface

// File: rtl/move_seq_frwrd_ramp.sv
// Saturating forward-speed accumulator: clamps at MAX going up, floors at 0 going down.
module frwrd_ramp
    import move_seq_pkg::*;
#(
    parameter logic [9:0] UP_STEP = RAMP_UP_STEP,
    parameter logic [9:0] DN_STEP = RAMP_DN_STEP,
    parameter logic [9:0] MAX     = FRWRD_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [9:0] frwrd_o
);
    logic [9:0]  frwrd_q, frwrd_d;
    logic [10:0] sum;

    always_comb begin
        sum     = {1'b0, frwrd_q} + {1'b0, UP_STEP};
        frwrd_d = frwrd_q;
        if (clr_i)
            frwrd_d = '0;
        else if (inc_i)
            frwrd_d = (sum > {1'b0, MAX}) ? MAX : sum[9:0];
        else if (dec_i)
            frwrd_d = (frwrd_q < DN_STEP) ? '0 : frwrd_q - DN_STEP;
    end

    always_ff @(posedge clk) begin
        if (rst) frwrd_q <= '0;
        else     frwrd_q <= frwrd_d;
    end

    assign frwrd_o = frwrd_q;
endmodule

// File: rtl/move_seq.sv
// Move sequencer: turn to heading, ramp up, count centre lines, ramp down, report done.
// Ramp step sizes follow MOVE_SEQ_FAST_SIM_EN via move_seq_pkg.
module move_seq
    import move_seq_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    move_seq_if.slave bus
);
    state_t      state_q, state_d;
    logic [11:0] dsrd_hdg_q;
    logic [3:0]  sqrs_q;
    logic [5:0]  line_cnt_q, line_cnt_d;
    logic        cntr_ir_prev_q;
    logic [11:0] error_q;
    logic        err_vld_q;
    logic [9:0]  frwrd;

    logic accept, busy, counting, line_edge, lines_done, aligned;
    logic ramp_inc, ramp_dec, ramp_clr;

    assign accept    = bus.cmd_vld && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign counting  = (state_q == RAMP_UP) || (state_q == CRUISE);
    assign line_edge = bus.cntrIR && !cntr_ir_prev_q;

    // Target comparison uses the count including this cycle's edge.
    assign line_cnt_d = accept                  ? 6'd0 :
                        (counting && line_edge) ? line_cnt_q + 6'd1 :
                                                  line_cnt_q;
    assign lines_done = (line_cnt_d == {2'b00, sqrs_q} * LINES_PER_SQ);

    assign aligned = err_vld_q &&
                     ($signed(error_q) <  $signed(HDG_TOL)) &&
                     ($signed(error_q) > -$signed(HDG_TOL));

    assign ramp_inc = bus.heading_rdy && (state_q == RAMP_UP);
    assign ramp_dec = bus.heading_rdy && (state_q == RAMP_DN);
    assign ramp_clr = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.cmd_vld) state_d = TURN;
            TURN:    if (aligned) state_d = (sqrs_q == 4'd0) ? DONE : RAMP_UP;
            RAMP_UP: begin
                if (lines_done)               state_d = RAMP_DN;
                else if (frwrd == FRWRD_MAX)  state_d = CRUISE;
            end
            CRUISE:  if (lines_done) state_d = RAMP_DN;
            RAMP_DN: if (frwrd == 10'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dsrd_hdg_q     <= '0;
            sqrs_q         <= '0;
            line_cnt_q     <= '0;
            cntr_ir_prev_q <= 1'b0;
            error_q        <= '0;
            err_vld_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_cnt_q     <= line_cnt_d;
            cntr_ir_prev_q <= bus.cntrIR;
            err_vld_q      <= bus.heading_rdy && busy;
            if (accept) begin
                dsrd_hdg_q <= bus.cmd_hdg;
                sqrs_q     <= bus.cmd_sqrs;
            end
            if (bus.heading_rdy && busy)
                error_q <= bus.heading - dsrd_hdg_q;
        end
    end

    frwrd_ramp u_ramp (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (ramp_clr),
        .inc_i  (ramp_inc),
        .dec_i  (ramp_dec),
        .frwrd_o(frwrd)
    );

    assign bus.cmd_rdy = (state_q == IDLE);
    assign bus.moving  = busy && (state_q != DONE);
    assign bus.mv_done = (state_q == DONE);
    assign bus.err_vld = err_vld_q;
    assign bus.error   = error_q;
    assign bus.frwrd   = frwrd;
endmodule

// File: tb/tb_move_seq.sv
// Self-checking bench for move_seq: scoreboarded heading errors plus ramp/sequencing checks.
module tb_move_seq;
`ifdef MOVE_SEQ_FAST_SIM_EN
    localparam logic [9:0] UP = 10'h020;
    localparam logic [9:0] DN = 10'h040;
`else
    localparam logic [9:0] UP = 10'h008;
    localparam logic [9:0] DN = 10'h010;
`endif
    localparam logic [9:0] TOP = 10'h120;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_seq_if bus();
    move_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          done_cnt = 0;
    logic [11:0] exp_q[$];
    logic [11:0] cur_hdg;
    logic [9:0]  exp_f;

    // Advance one cycle, sample #1 later, and retire any error update against the scoreboard.
    task automatic tick();
        logic [11:0] e;
        @(posedge clk); #1;
        if (bus.mv_done === 1'b1) done_cnt++;
        if (bus.err_vld === 1'b1) begin
            chk_cnt++;
            if (exp_q.size() == 0)
                $display("FAIL err_vld_spurious: error=%h with no strobe pending", bus.error);
            else begin
                e = exp_q.pop_front();
                if (bus.error !== e) $display("FAIL error_val: got %h want %h", bus.error, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic strobe(input logic [11:0] h);
        bus.heading     = h;
        bus.heading_rdy = 1'b1;
        exp_q.push_back(h - cur_hdg);
        tick();
        bus.heading_rdy = 1'b0;
        chk_cnt++;
        if (bus.err_vld !== 1'b1) $display("FAIL err_vld_latency: got %b want 1", bus.err_vld);
        else pass_cnt++;
    endtask

    task automatic up_step(input logic [11:0] h);
        strobe(h);
        exp_f = (exp_f + UP > TOP) ? TOP : exp_f + UP;
        chk_cnt++;
        if (bus.frwrd !== exp_f) $display("FAIL ramp_up: frwrd got %h want %h", bus.frwrd, exp_f);
        else pass_cnt++;
    endtask

    task automatic send_cmd(input logic [11:0] h, input logic [3:0] s);
        int n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 50) begin tick(); n++; end
        chk_cnt++;
        if (bus.cmd_rdy !== 1'b1) $display("FAIL cmd_rdy_wait: got %b want 1", bus.cmd_rdy);
        else pass_cnt++;
        bus.cmd_vld = 1'b1; bus.cmd_hdg = h; bus.cmd_sqrs = s;
        cur_hdg = h; exp_f = '0;
        tick();
        bus.cmd_vld = 1'b0;
        chk_cnt++;
        if (bus.cmd_rdy !== 1'b0 || bus.moving !== 1'b1)
            $display("FAIL accept: cmd_rdy=%b moving=%b want 0/1", bus.cmd_rdy, bus.moving);
        else pass_cnt++;
    endtask

    // On-heading sample, then one idle cycle for the TURN exit.
    task automatic align();
        strobe(cur_hdg);
        tick();
    endtask

    task automatic lines(input int n);
        repeat (n) begin
            bus.cntrIR = 1'b1; tick();
            bus.cntrIR = 1'b0; tick();
        end
    endtask

    task automatic finish_down();
        int n = 0;
        int want = (int'(exp_f) + int'(DN) - 1) / int'(DN);
        int d0 = done_cnt;
        while (exp_f != 10'd0 && n < 40) begin
            strobe(cur_hdg);
            exp_f = (exp_f < DN) ? 10'd0 : exp_f - DN;
            n++;
            chk_cnt++;
            if (bus.frwrd !== exp_f) $display("FAIL ramp_dn: frwrd got %h want %h", bus.frwrd, exp_f);
            else pass_cnt++;
        end
        chk_cnt++;
        if (n != want) $display("FAIL ramp_dn_len: strobes got %0d want %0d", n, want);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.mv_done !== 1'b1 || bus.moving !== 1'b0 || bus.frwrd !== 10'd0)
            $display("FAIL done_state: mv_done=%b moving=%b frwrd=%h want 1/0/000",
                     bus.mv_done, bus.moving, bus.frwrd);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.cmd_rdy !== 1'b1 || bus.mv_done !== 1'b0 || done_cnt != d0 + 1)
            $display("FAIL back_idle: cmd_rdy=%b mv_done=%b pulses=%0d want 1/0/1",
                     bus.cmd_rdy, bus.mv_done, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        chk_cnt++;
        if (bus.cmd_rdy !== 1'b1 || bus.moving !== 1'b0 || bus.err_vld !== 1'b0 ||
            bus.error !== 12'h000 || bus.frwrd !== 10'h000 || bus.mv_done !== 1'b0)
            $display("FAIL reset_vals: rdy=%b mov=%b ev=%b err=%h fw=%h done=%b want 1/0/0/000/000/0",
                     bus.cmd_rdy, bus.moving, bus.err_vld, bus.error, bus.frwrd, bus.mv_done);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_sqrs();
        int d0;
        send_cmd(12'h000, 4'd0);
        d0 = done_cnt;
        strobe(12'h010);
        chk_cnt++;
        if (bus.error !== 12'h010) $display("FAIL zero_sqrs_err: got %h want 010", bus.error);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.mv_done !== 1'b1 || bus.frwrd !== 10'd0 || bus.moving !== 1'b0)
            $display("FAIL zero_sqrs_done: mv_done=%b frwrd=%h moving=%b want 1/000/0",
                     bus.mv_done, bus.frwrd, bus.moving);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.cmd_rdy !== 1'b1 || done_cnt != d0 + 1)
            $display("FAIL zero_sqrs_idle: cmd_rdy=%b pulses=%0d want 1/1", bus.cmd_rdy, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_turn_neg();
        send_cmd(12'h3FF, 4'd1);
        strobe(12'h000);
        chk_cnt++;
        if (bus.error !== 12'hC01) $display("FAIL turn_neg_err: got %h want C01", bus.error);
        else pass_cnt++;
        tick();
        strobe(12'h000);
        tick();
        chk_cnt++;
        if (bus.frwrd !== 10'd0 || bus.moving !== 1'b1)
            $display("FAIL turn_hold: frwrd=%h moving=%b want 000/1", bus.frwrd, bus.moving);
        else pass_cnt++;
        strobe(12'h3F0);
        chk_cnt++;
        if (bus.error !== 12'hFF1) $display("FAIL turn_exit_err: got %h want FF1", bus.error);
        else pass_cnt++;
        tick();
        cur_hdg = 12'h3FF;
        up_step(12'h3F0);
        lines(2);
        finish_down();
    endtask

    task automatic test_full_move();
        send_cmd(12'h100, 4'd1);
        align();
        repeat (40) up_step(12'h100);
        chk_cnt++;
        if (bus.frwrd !== TOP) $display("FAIL cruise_top: frwrd got %h want %h", bus.frwrd, TOP);
        else pass_cnt++;
        lines(2);
        finish_down();
    endtask

    task automatic test_early_lines();
        send_cmd(12'h050, 4'd1);
        lines(1);
        align();
        while (exp_f < 10'h040 - UP) up_step(12'h050);
        lines(1);
        up_step(12'h050);
        lines(1);
        chk_cnt++;
        if (bus.frwrd !== 10'h040) $display("FAIL early_peak: frwrd got %h want 040", bus.frwrd);
        else pass_cnt++;
        finish_down();
    endtask

    task automatic test_busy_ignore();
        send_cmd(12'h200, 4'd1);
        align();
        repeat (40) up_step(12'h200);
        bus.cmd_vld = 1'b1; bus.cmd_hdg = 12'h7F0; bus.cmd_sqrs = 4'd5;
        tick();
        bus.cmd_vld = 1'b0;
        chk_cnt++;
        if (bus.cmd_rdy !== 1'b0 || bus.moving !== 1'b1)
            $display("FAIL busy_ignore: cmd_rdy=%b moving=%b want 0/1", bus.cmd_rdy, bus.moving);
        else pass_cnt++;
        strobe(12'h210);
        chk_cnt++;
        if (bus.error !== 12'h010) $display("FAIL busy_hdg_kept: error got %h want 010", bus.error);
        else pass_cnt++;
        lines(2);
        finish_down();
    endtask

    task automatic test_reset_mid();
        int d0;
        send_cmd(12'h000, 4'd2);
        align();
        repeat (45) up_step(12'h000);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        chk_cnt++;
        if (bus.frwrd !== 10'd0 || bus.moving !== 1'b0 || bus.cmd_rdy !== 1'b1 || bus.mv_done !== 1'b0)
            $display("FAIL reset_mid: frwrd=%h moving=%b cmd_rdy=%b mv_done=%b want 000/0/1/0",
                     bus.frwrd, bus.moving, bus.cmd_rdy, bus.mv_done);
        else pass_cnt++;
        rst = 1'b0;
        repeat (5) tick();
        chk_cnt++;
        if (done_cnt != d0) $display("FAIL reset_no_done: pulses got %0d want 0", done_cnt - d0);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_vld = 1'b0; bus.cmd_hdg = '0; bus.cmd_sqrs = '0;
        bus.heading = '0; bus.heading_rdy = 1'b0; bus.cntrIR = 1'b0;
        cur_hdg = '0; exp_f = '0;
        test_reset();
        test_zero_sqrs();
        test_turn_neg();
        test_full_move();
        test_early_lines();
        test_busy_ignore();
        test_reset_mid();
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d pending want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
